asic_turbo_sequencer: RTL and testbench



---
 rtl/asic_turbo_sequencer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_asic_turbo_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asic_turbo_sequencer.sv
// -----------------------------------------------------------------------------
// asic_turbo_sequencer
//
// Runs one decode on the external turbo-decoder ASIC: pulses the ASIC reset,
// streams 7-bit soft symbols onto asic_in under asic_enable_f, issues Go,
// waits for Start, then collects the decoded bits the ASIC clocks out on Dclk.
// It takes the place of software bit-banging of the ASIC control pins and
// sits between the Avalon register/FIFO logic and the ASIC pins.
//
// Parameters
//   CLK_DIV  clk cycles per asic_clock half-period (>= 1)
//   LEN_W    width of the frame-length counters
//   RST_CYC  clk cycles asic_nreset is held low at the start of a run
//   TIMEOUT  clk cycles allowed in WAIT_START, and per bit in CAPTURE
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   cmd_start          pulse: start a run (ignored while busy)
//   cmd_abort          pulse: abandon any run, back to IDLE
//   cmd_mode, cmd_len  run parameters, latched on an accepted cmd_start
//   in_valid/in_data   soft-symbol source; in_ready marks the accept cycle
//   out_valid/out_data one pulse per decoded bit (no backpressure)
//   busy               high while a run is in progress
//   done, err_timeout  sticky status, cleared by the next cmd_start
//   asic_*  (outputs)  ASIC control pins and symbol bus
//   asic_start, asic_dclk, asic_bitout1  asynchronous ASIC outputs
// -----------------------------------------------------------------------------
module asic_turbo_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 16,
  parameter int RST_CYC = 16,
  parameter int TIMEOUT = 1048576
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  input  logic [6:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             asic_nreset,
  output logic             asic_clock,
  output logic             asic_go,
  output logic             asic_mode,
  output logic             asic_enable_f,
  output logic [6:0]       asic_in,
  input  logic             asic_start,
  input  logic             asic_dclk,
  input  logic             asic_bitout1
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_ASIC,
    S_LOAD,
    S_GO,
    S_WAIT_START,
    S_CAPTURE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic [TMR_W-1:0]   timer;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   load_cnt;
  logic [LEN_W-1:0]   cap_cnt;

  // Two-flop synchronisers for the asynchronous ASIC outputs, plus one extra
  // stage on dclk for edge detection.
  logic [1:0]         start_sync;
  logic [1:0]         dclk_sync;
  logic [1:0]         bit_sync;
  logic               dclk_prev;

  logic               tick_half;
  logic               tick_fall;
  logic               dclk_rise;

  // tick_half: the divider wraps and asic_clock toggles at the coming edge.
  // tick_fall: that toggle takes asic_clock from 1 to 0. Symbol and Go
  // changes are aligned to it so they are stable around the ASIC's rising edge.
  assign tick_half = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign tick_fall = tick_half && asic_clock;
  assign dclk_rise = dclk_sync[1] && !dclk_prev;

  // Decoded from registers only, so the source sees a clean handshake window.
  assign in_ready = (state == S_LOAD) && tick_fall && (load_cnt < len_q);
  assign busy     = !(state inside {S_IDLE, S_DONE, S_ERROR});

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      start_sync <= '0;
      dclk_sync  <= '0;
      bit_sync   <= '0;
      dclk_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each stage sample the previous
      // stage's pre-edge value; blocking here would collapse the chain.
      start_sync <= {start_sync[0], asic_start};
      dclk_sync  <= {dclk_sync[0], asic_dclk};
      bit_sync   <= {bit_sync[0], asic_bitout1};
      dclk_prev  <= dclk_sync[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM, ASIC clock divider and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      rst_cnt       <= '0;
      timer         <= '0;
      len_q         <= '0;
      load_cnt      <= '0;
      cap_cnt       <= '0;
      out_valid     <= 1'b0;
      out_data      <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      asic_nreset   <= 1'b0;
      asic_clock    <= 1'b0;
      asic_go       <= 1'b0;
      asic_mode     <= 1'b0;
      asic_enable_f <= 1'b0;
      asic_in       <= '0;
    end else begin
      out_valid <= 1'b0;

      // Free-running divider; RESET_ASIC parks it at zero below.
      if (state != S_RESET_ASIC) begin
        if (tick_half) begin
          div_cnt    <= '0;
          asic_clock <= ~asic_clock;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      if (cmd_abort) begin
        // Sticky status survives an abort; everything run-related clears.
        state         <= S_IDLE;
        asic_go       <= 1'b0;
        asic_enable_f <= 1'b0;
        asic_nreset   <= 1'b1;
        rst_cnt       <= '0;
        timer         <= '0;
        load_cnt      <= '0;
        cap_cnt       <= '0;
      end else if (cmd_start && !busy) begin
        len_q       <= cmd_len;
        asic_mode   <= cmd_mode;
        done        <= 1'b0;
        err_timeout <= 1'b0;
        rst_cnt     <= '0;
        timer       <= '0;
        load_cnt    <= '0;
        cap_cnt     <= '0;
        if (cmd_len == '0) begin
          // Nothing to decode: finish without touching the ASIC pins.
          state       <= S_DONE;
          done        <= 1'b1;
          asic_nreset <= 1'b1;
        end else begin
          state       <= S_RESET_ASIC;
          asic_nreset <= 1'b0;
          asic_clock  <= 1'b0;
          div_cnt     <= '0;
        end
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            asic_nreset <= 1'b1;
          end

          S_ERROR: begin
            // Keep the ASIC parked in reset until software restarts a run.
            asic_nreset <= 1'b0;
          end

          S_RESET_ASIC: begin
            asic_clock <= 1'b0;
            div_cnt    <= '0;
            if (rst_cnt == RST_W'(RST_CYC - 1)) begin
              rst_cnt     <= '0;
              asic_nreset <= 1'b1;
              state       <= S_LOAD;
            end else begin
              rst_cnt <= rst_cnt + RST_W'(1);
            end
          end

          S_LOAD: begin
            if (tick_fall) begin
              if (load_cnt < len_q) begin
                if (in_valid) begin
                  asic_in       <= in_data;
                  asic_enable_f <= 1'b1;
                  load_cnt      <= load_cnt + LEN_W'(1);
                end else begin
                  // Bubble: the ASIC sees enable low for this whole period.
                  asic_enable_f <= 1'b0;
                end
              end else begin
                // Last symbol period has ended; Go spans the next full period.
                asic_enable_f <= 1'b0;
                asic_go       <= 1'b1;
                state         <= S_GO;
              end
            end
          end

          S_GO: begin
            if (tick_fall) begin
              asic_go <= 1'b0;
              timer   <= '0;
              state   <= S_WAIT_START;
            end
          end

          S_WAIT_START: begin
            if (start_sync[1]) begin
              timer <= '0;
              state <= S_CAPTURE;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              asic_nreset <= 1'b0;
              state       <= S_ERROR;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end

          S_CAPTURE: begin
            if (dclk_rise) begin
              // bitout1 shares dclk's synchroniser depth, so bit_sync holds
              // the value the ASIC presented at its Dclk edge.
              out_valid <= 1'b1;
              out_data  <= bit_sync[1];
              timer     <= '0;
              if ((cap_cnt + LEN_W'(1)) == len_q) begin
                cap_cnt <= '0;
                done    <= 1'b1;
                state   <= S_DONE;
              end else begin
                cap_cnt <= cap_cnt + LEN_W'(1);
              end
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              asic_nreset <= 1'b0;
              state       <= S_ERROR;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_asic_turbo_sequencer.sv
// -----------------------------------------------------------------------------
// tb_asic_turbo_sequencer
//
// Directed sequence of runs with randomised payloads, bubbles and ASIC
// response timing. Expected values come from a period-level model of the
// load/Go schedule and from queues of the symbols and bits the bench supplies.
// -----------------------------------------------------------------------------
module tb_asic_turbo_sequencer;

  localparam int CLK_DIV = 4;
  localparam int LEN_W   = 16;
  localparam int RST_CYC = 16;
  localparam int TIMEOUT = 100;
  localparam int PERIOD  = 2 * CLK_DIV;

  typedef struct packed {
    logic       go;
    logic       en;
    logic [6:0] sym;
  } rise_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_start, cmd_abort, cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic [6:0]       in_data;
  logic             in_ready, out_valid, out_data, busy, done, err_timeout;
  logic             asic_nreset, asic_clock, asic_go, asic_mode, asic_enable_f;
  logic [6:0]       asic_in;
  logic             asic_start, asic_dclk, asic_bitout1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  asic_turbo_sequencer #(
    .CLK_DIV (CLK_DIV),
    .LEN_W   (LEN_W),
    .RST_CYC (RST_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_start     (cmd_start),
    .cmd_abort     (cmd_abort),
    .cmd_mode      (cmd_mode),
    .cmd_len       (cmd_len),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done),
    .err_timeout   (err_timeout),
    .asic_nreset   (asic_nreset),
    .asic_clock    (asic_clock),
    .asic_go       (asic_go),
    .asic_mode     (asic_mode),
    .asic_enable_f (asic_enable_f),
    .asic_in       (asic_in),
    .asic_start    (asic_start),
    .asic_dclk     (asic_dclk),
    .asic_bitout1  (asic_bitout1)
  );

  // ---------------------------------------------------------------------------
  // Symbol source: in_valid is decided once per ASIC period (after each
  // in_ready cycle), low for tick k when drop_mask[k] is set.
  // ---------------------------------------------------------------------------
  logic [6:0]  src_sym[$];
  logic        run_bits[$];
  logic [31:0] drop_mask;
  int          src_idx;
  int          tick_idx;
  bit          drv_en;

  initial begin : driver
    bit hs;
    bit tk;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready;
      tk = in_ready;
      @(posedge clk);
      #1;
      if (drv_en) begin
        if (hs) src_idx++;
        if (tk) tick_idx++;
        if (src_idx < src_sym.size() && !(tick_idx < 32 && drop_mask[tick_idx])) begin
          in_valid = 1'b1;
          in_data  = src_sym[src_idx];
        end else begin
          in_valid = 1'b0;
          in_data  = 7'($urandom);
        end
      end else begin
        in_valid = 1'b0;
        in_data  = 7'($urandom);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pin monitor (sampled on the falling clk edge)
  // ---------------------------------------------------------------------------
  logic [6:0] hs_q[$];
  logic       out_q[$];
  rise_t      rise_q[$];
  int         nrst_low_cnt, go_hi_cnt, go_pulses, en_toggles, nrst_toggles;
  bit         rec_en;
  logic       prev_go, prev_en, prev_nrst, prev_clk;

  always @(negedge clk) begin
    if (in_valid && in_ready) hs_q.push_back(in_data);
    if (out_valid) out_q.push_back(out_data);
    if (asic_nreset === 1'b0) nrst_low_cnt++;
    if (asic_go === 1'b1) go_hi_cnt++;
    if (asic_go === 1'b1 && prev_go !== 1'b1) go_pulses++;
    if (asic_enable_f !== prev_en) en_toggles++;
    if (asic_nreset !== prev_nrst) nrst_toggles++;
    // The ASIC samples its inputs on each asic_clock rising edge.
    if (rec_en && asic_clock === 1'b1 && prev_clk === 1'b0)
      rise_q.push_back(rise_t'{go: asic_go, en: asic_enable_f, sym: asic_in});
    if (asic_nreset === 1'b1 && prev_nrst === 1'b0) rec_en = 1'b1;
    prev_go   = asic_go;
    prev_en   = asic_enable_f;
    prev_nrst = asic_nreset;
    prev_clk  = asic_clock;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_mon();
    hs_q.delete();
    out_q.delete();
    rise_q.delete();
    nrst_low_cnt = 0;
    go_hi_cnt    = 0;
    go_pulses    = 0;
    en_toggles   = 0;
    nrst_toggles = 0;
    rec_en       = 1'b0;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] len, input logic mode);
    cmd_start = 1'b1;
    cmd_len   = len;
    cmd_mode  = mode;
    tick();
    cmd_start = 1'b0;
    cmd_len   = LEN_W'($urandom);
    cmd_mode  = 1'($urandom);
  endtask

  task automatic arm_source(input int len, input logic [31:0] drop);
    drop_mask = drop;
    src_idx   = 0;
    tick_idx  = 0;
    drv_en    = 1'b1;
    if (src_sym.size() == 0)
      for (int i = 0; i < len; i++) src_sym.push_back(7'($urandom));
    if (run_bits.size() == 0)
      for (int i = 0; i < len; i++) run_bits.push_back(1'($urandom));
  endtask

  task automatic wait_go_fall(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (go_pulses > 0 && asic_go === 1'b0) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  // One complete run, with the bench acting as the ASIC on the output side.
  task automatic do_run(input int len, input logic mode, input logic [31:0] drop,
                        input bit from_err, input bit poke);
    rise_t exp_r[$];
    bit    ok;
    int    acc, k, n;

    clear_mon();
    arm_source(len, drop);
    pulse_start(LEN_W'(len), mode);
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err_timeout, 0);
    tick();
    check("mode_latched", asic_mode, mode);
    if (poke) begin
      tick(3);
      pulse_start(LEN_W'(len + 3), ~mode);
      check("busy_start_ignored_mode", asic_mode, mode);
    end

    wait_go_fall(ok);
    check("go_seen", ok, 1);
    tick();
    if (ok) begin
      tick($urandom_range(2, 20));
      asic_start = 1'b1;
      foreach (run_bits[i]) begin
        asic_bitout1 = run_bits[i];
        tick(3);
        asic_dclk = 1'b1;
        tick(3);
        asic_dclk = 1'b0;
        tick($urandom_range(2, 10));
      end
      n = 0;
      while (done !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
    end
    check("run_done", done, 1);
    check("run_busy_end", busy, 0);
    check("run_err", err_timeout, 0);
    asic_start = 1'b0;
    drv_en     = 1'b0;

    check("hs_count", hs_q.size(), len);
    for (int i = 0; i < len && i < hs_q.size(); i++) check("hs_sym", hs_q[i], src_sym[i]);
    check("out_count", out_q.size(), len);
    for (int i = 0; i < len && i < out_q.size(); i++) check("out_bit", out_q[i], run_bits[i]);
    check("nreset_low_cycles", nrst_low_cnt, RST_CYC + int'(from_err));
    check("go_cycles", go_hi_cnt, PERIOD);
    check("go_pulses", go_pulses, 1);

    // Period-level schedule: one ASIC period before the first tick, then one
    // period per tick (symbol or bubble), then the Go period, then idle.
    exp_r.push_back(rise_t'{go: 1'b0, en: 1'b0, sym: 7'h00});
    acc = 0;
    k   = 0;
    while (acc < len) begin
      if (k < 32 && drop[k]) begin
        exp_r.push_back(rise_t'{go: 1'b0, en: 1'b0, sym: 7'h00});
      end else begin
        exp_r.push_back(rise_t'{go: 1'b0, en: 1'b1, sym: src_sym[acc]});
        acc++;
      end
      k++;
    end
    exp_r.push_back(rise_t'{go: 1'b1, en: 1'b0, sym: 7'h00});
    exp_r.push_back(rise_t'{go: 1'b0, en: 1'b0, sym: 7'h00});
    check("asic_periods_seen", rise_q.size() >= exp_r.size(), 1);
    for (int i = 0; i < exp_r.size() && i < rise_q.size(); i++) begin
      check("period_go", rise_q[i].go, exp_r[i].go);
      check("period_en", rise_q[i].en, exp_r[i].en);
      if (exp_r[i].en) check("period_sym", rise_q[i].sym, exp_r[i].sym);
    end
    src_sym.delete();
    run_bits.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    bit ok;
    int n;

    reset        = 1'b1;
    cmd_start    = 1'b0;
    cmd_abort    = 1'b0;
    cmd_mode     = 1'b0;
    cmd_len      = '0;
    asic_start   = 1'b0;
    asic_dclk    = 1'b0;
    asic_bitout1 = 1'b0;
    drv_en       = 1'b0;
    drop_mask    = '0;
    src_idx      = 0;
    tick_idx     = 0;
    clear_mon();

    // Reset values
    tick(3);
    check("reset_outputs",
          {asic_nreset, asic_clock, asic_go, asic_enable_f, asic_mode, asic_in,
           in_ready, out_valid, out_data, busy, done, err_timeout}, 0);
    reset = 1'b0;
    tick(5);
    check("idle_nreset", asic_nreset, 1);
    check("idle_busy", busy, 0);

    // Directed run: four known symbols and bits, no bubbles
    src_sym  = '{7'h11, 7'h22, 7'h33, 7'h44};
    run_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_run(4, 1'b1, 32'h0, 1'b0, 1'b0);

    // Bubble on the second tick of a three-symbol load; stray start while busy
    do_run(3, 1'b0, 32'h2, 1'b0, 1'b1);

    // Randomised runs
    for (int r = 0; r < 4; r++)
      do_run($urandom_range(1, 8), 1'($urandom), $urandom & $urandom, 1'b0, r == 2);

    // Start never arrives: WAIT_START times out
    clear_mon();
    arm_source(2, 32'h0);
    pulse_start(LEN_W'(2), 1'b0);
    wait_go_fall(ok);
    check("to_go_seen", ok, 1);
    n = 0;
    while (asic_nreset !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    tick();
    drv_en = 1'b0;
    check("timeout_err", err_timeout, 1);
    check("timeout_busy", busy, 0);
    check("timeout_done", done, 0);
    tick(10);
    check("error_holds_nreset", asic_nreset, 0);
    src_sym.delete();
    run_bits.delete();

    // Restart from ERROR clears err_timeout and completes normally
    do_run($urandom_range(1, 4), 1'b1, 32'h0, 1'b1, 1'b0);

    // Abort during LOAD after two of five symbols
    clear_mon();
    arm_source(5, 32'h0);
    pulse_start(LEN_W'(5), 1'b1);
    n = 0;
    while (hs_q.size() < 2 && n < 1000) begin
      tick();
      n++;
    end
    check("abort_two_loaded", hs_q.size(), 2);
    tick($urandom_range(0, 3));
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_enable_f", asic_enable_f, 0);
    check("abort_go", asic_go, 0);
    tick(30);
    check("abort_no_more_hs", hs_q.size(), 2);
    drv_en = 1'b0;
    src_sym.delete();
    run_bits.delete();
    do_run(5, 1'b0, 32'h0, 1'b0, 1'b0);

    // Zero-length run: done next cycle, ASIC pins untouched
    clear_mon();
    pulse_start('0, 1'($urandom));
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    tick(20);
    check("len0_nreset_toggles", nrst_toggles, 0);
    check("len0_go_pulses", go_pulses, 0);
    check("len0_enable_toggles", en_toggles, 0);
    check("len0_done_sticky", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
